// File: rtl/vga_pkg.sv
// +------------------------------------------------------------------+
// | vga_pkg : shared screen geometry, pixel types and sequencer state |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic [7:0] x_t;
  typedef logic [6:0] y_t;
  typedef logic [2:0] colour_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    FILL_REL = 3'd2,
    FIG      = 3'd3,
    DONE     = 3'd4
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/plot_mux_reg.sv
// +------------------------------------------------------------------+
// | plot_mux_reg : engine plot select, bounds clip, output register   |
// | and saturating plot counter. rev 1.0                              |
// +------------------------------------------------------------------+
`default_nettype none

module plot_mux_reg
  import vga_pkg::*;
#(
  parameter int MAX_X = vga_pkg::SCREEN_W,
  parameter int MAX_Y = vga_pkg::SCREEN_H
) (
  input  logic       clk,
  input  logic       rst_n,
  input  seq_state_t state,
  input  logic       clr,
  input  x_t         fill_x,
  input  y_t         fill_y,
  input  colour_t    fill_colour,
  input  logic       fill_plot,
  input  x_t         fig_x,
  input  y_t         fig_y,
  input  colour_t    fig_colour,
  input  logic       fig_plot,
  output x_t         vga_x,
  output y_t         vga_y,
  output colour_t    vga_colour,
  output logic       vga_plot,
  output logic [15:0] plot_count
);

  logic    has_src;
  x_t      sel_x;
  y_t      sel_y;
  colour_t sel_colour;
  logic    sel_plot;
  logic    emit;

  always_comb begin
    has_src    = 1'b0;
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    sel_plot   = 1'b0;
    case (state)
      FILL: begin
        has_src    = 1'b1;
        sel_x      = fill_x;
        sel_y      = fill_y;
        sel_colour = fill_colour;
        sel_plot   = fill_plot;
      end
      FIG: begin
        has_src    = 1'b1;
        sel_x      = fig_x;
        sel_y      = fig_y;
        sel_colour = fig_colour;
        sel_plot   = fig_plot;
      end
      default: ;
    endcase
  end

  assign emit = sel_plot && (32'(sel_x) < MAX_X) && (32'(sel_y) < MAX_Y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      plot_count <= '0;
    end else begin
      vga_plot <= emit;
      // Coordinates track the selected engine even for clipped pixels.
      if (has_src) begin
        vga_x      <= sel_x;
        vga_y      <= sel_y;
        vga_colour <= sel_colour;
      end
      if (clr)
        plot_count <= '0;
      else if (emit && (plot_count != 16'hFFFF))
        plot_count <= plot_count + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/plot_sequencer.sv
// +------------------------------------------------------------------+
// | plot_sequencer : runs clear engine then figure engine per frame,  |
// | muxing their plots onto the VGA adapter. rev 1.0                  |
// +------------------------------------------------------------------+
`default_nettype none

module plot_sequencer
  import vga_pkg::*;
#(
  parameter int SCREEN_W = vga_pkg::SCREEN_W,
  parameter int SCREEN_H = vga_pkg::SCREEN_H,
  parameter int TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        done,
  output logic        err,
  output logic        fill_start,
  input  logic        fill_done,
  input  x_t          fill_x,
  input  y_t          fill_y,
  input  colour_t     fill_colour,
  input  logic        fill_plot,
  output logic        fig_start,
  input  logic        fig_done,
  input  x_t          fig_x,
  input  y_t          fig_y,
  input  colour_t     fig_colour,
  input  logic        fig_plot,
  output x_t          vga_x,
  output y_t          vga_y,
  output colour_t     vga_colour,
  output logic        vga_plot,
  output logic [15:0] plot_count
);

  // Timer starts at 0 on phase entry, so this value is the TIMEOUT-th cycle.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  seq_state_t  state;
  logic [15:0] timer;
  logic        timeout_hit;
  logic        run_clr;

  assign timeout_hit = (timer == TIMER_LAST);
  assign run_clr     = (state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      err        <= 1'b0;
      done       <= 1'b0;
      fill_start <= 1'b0;
      fig_start  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err        <= 1'b0;
            timer      <= '0;
            fill_start <= 1'b1;
            state      <= FILL;
          end
        end
        FILL: begin
          timer <= timer + 16'd1;
          if (fill_done) begin
            fill_start <= 1'b0;
            state      <= FILL_REL;
          end else if (timeout_hit) begin
            fill_start <= 1'b0;
            err        <= 1'b1;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        FILL_REL: begin
          timer <= timer + 16'd1;
          if (!fill_done) begin
            timer     <= '0;
            fig_start <= 1'b1;
            state     <= FIG;
          end else if (timeout_hit) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        FIG: begin
          timer <= timer + 16'd1;
          if (fig_done) begin
            fig_start <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (timeout_hit) begin
            fig_start <= 1'b0;
            err       <= 1'b1;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Hold off until both engines have released their done handshakes.
          if (!start && !fig_done && !fill_done) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          fill_start <= 1'b0;
          fig_start  <= 1'b0;
          done       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  plot_mux_reg #(
    .MAX_X (SCREEN_W),
    .MAX_Y (SCREEN_H)
  ) u_plot_mux_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .state       (state),
    .clr         (run_clr),
    .fill_x      (fill_x),
    .fill_y      (fill_y),
    .fill_colour (fill_colour),
    .fill_plot   (fill_plot),
    .fig_x       (fig_x),
    .fig_y       (fig_y),
    .fig_colour  (fig_colour),
    .fig_plot    (fig_plot),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .plot_count  (plot_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_plot_sequencer.sv
// +------------------------------------------------------------------+
// | tb_plot_sequencer : directed self-checking bench for the frame    |
// | sequencer. rev 1.0                                                |
// +------------------------------------------------------------------+
`default_nettype none

module tb_plot_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        done, err, fill_start, fig_start;
  logic        fill_done, fill_plot, fig_done, fig_plot;
  logic [7:0]  fill_x, fig_x, vga_x;
  logic [6:0]  fill_y, fig_y, vga_y;
  logic [2:0]  fill_colour, fig_colour, vga_colour;
  logic        vga_plot;
  logic [15:0] plot_count;

  // second instance with a short timeout
  logic        t_start, t_done, t_err, t_fill_start, t_fig_start;
  logic        t_fill_done, t_fig_done;
  logic [7:0]  t_vga_x;
  logic [6:0]  t_vga_y;
  logic [2:0]  t_vga_colour;
  logic        t_vga_plot;
  logic [15:0] t_plot_count;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  plot_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .err(err),
    .fill_start(fill_start), .fill_done(fill_done), .fill_x(fill_x),
    .fill_y(fill_y), .fill_colour(fill_colour), .fill_plot(fill_plot),
    .fig_start(fig_start), .fig_done(fig_done), .fig_x(fig_x),
    .fig_y(fig_y), .fig_colour(fig_colour), .fig_plot(fig_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .plot_count(plot_count)
  );

  plot_sequencer #(.TIMEOUT(100)) dut_to (
    .clk(clk), .rst_n(rst_n), .start(t_start), .done(t_done), .err(t_err),
    .fill_start(t_fill_start), .fill_done(t_fill_done), .fill_x(8'd0),
    .fill_y(7'd0), .fill_colour(3'd0), .fill_plot(1'b0),
    .fig_start(t_fig_start), .fig_done(t_fig_done), .fig_x(8'd0),
    .fig_y(7'd0), .fig_colour(3'd0), .fig_plot(1'b0),
    .vga_x(t_vga_x), .vga_y(t_vga_y), .vga_colour(t_vga_colour),
    .vga_plot(t_vga_plot), .plot_count(t_plot_count)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; t_start = 1'b0;
    fill_done = 1'b0; fill_plot = 1'b0; fill_x = '0; fill_y = '0; fill_colour = '0;
    fig_done = 1'b0; fig_plot = 1'b0; fig_x = '0; fig_y = '0; fig_colour = '0;
    t_fill_done = 1'b0; t_fig_done = 1'b0;
    step();
    vectors++;
    if ({done, err, fill_start, fig_start, vga_plot} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00000", {done, err, fill_start, fig_start, vga_plot});
    end
    vectors++;
    if ({vga_x, vga_y, vga_colour, plot_count} !== 34'b0) begin
      miscompares++;
      $display("FAIL reset_data: got x=%0d y=%0d c=%0d cnt=%0d want all 0", vga_x, vga_y, vga_colour, plot_count);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_frame();
    int overlap = 0;
    int bad     = 0;
    start = 1'b1;
    step();
    vectors++;
    if (fill_start !== 1'b1 || fig_start !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_fill_start: got fill=%b fig=%b want fill=1 fig=0", fill_start, fig_start);
    end
    for (int i = 0; i < 19200; i++) begin
      fill_x = 8'(i % 160); fill_y = 7'(i / 160); fill_colour = 3'(i);
      fill_plot = 1'b1; fill_done = (i == 19199);
      fig_x = 8'd3; fig_y = 7'd3; fig_colour = 3'd7; fig_plot = 1'b1;
      step();
      if (vga_plot !== 1'b1 || vga_x !== 8'(i % 160) || vga_y !== 7'(i / 160) || vga_colour !== 3'(i))
        bad++;
      if (fill_start && fig_start) overlap++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL frame_fill_plots: got %0d wrong cycles want 0", bad);
    end
    vectors++;
    if (fill_start !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_fill_release: got fill_start=%b want 0", fill_start);
    end
    fill_done = 1'b0; fill_x = 8'd1; fill_y = 7'd1; fig_plot = 1'b0;
    step();
    vectors++;
    if (vga_plot !== 1'b0 || fig_start !== 1'b1 || plot_count !== 16'd19200) begin
      miscompares++;
      $display("FAIL frame_to_fig: got plot=%b fig_start=%b cnt=%0d want 0 1 19200", vga_plot, fig_start, plot_count);
    end
    bad = 0;
    for (int j = 0; j < 100; j++) begin
      fig_x = 8'(j); fig_y = 7'(j); fig_colour = 3'(j + 1);
      fig_plot = 1'b1; fig_done = (j == 99);
      fill_x = 8'd2; fill_y = 7'd2; fill_colour = 3'd6; fill_plot = 1'b1;
      step();
      if (vga_plot !== 1'b1 || vga_x !== 8'(j) || vga_y !== 7'(j) || vga_colour !== 3'(j + 1))
        bad++;
      if (fill_start && fig_start) overlap++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL frame_fig_plots: got %0d wrong cycles want 0", bad);
    end
    vectors++;
    if (done !== 1'b1 || err !== 1'b0 || fig_start !== 1'b0 || plot_count !== 16'd19300) begin
      miscompares++;
      $display("FAIL frame_done: got done=%b err=%b fig_start=%b cnt=%0d want 1 0 0 19300", done, err, fig_start, plot_count);
    end
    vectors++;
    if (overlap !== 0) begin
      miscompares++;
      $display("FAIL frame_start_overlap: got %0d cycles want 0", overlap);
    end
    fig_plot = 1'b0; fill_plot = 1'b0; fig_done = 1'b0;
  endtask

  task automatic test_bounds();
    step();
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_held: got %b want 1", done);
    end
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    vectors++;
    if (plot_count !== 16'd0 || fill_start !== 1'b1) begin
      miscompares++;
      $display("FAIL rerun_clear: got cnt=%0d fill_start=%b want 0 1", plot_count, fill_start);
    end
    fill_done = 1'b1;
    step();
    fill_done = 1'b0;
    step();
    fig_x = 8'd170; fig_y = 7'd10; fig_colour = 3'd1; fig_plot = 1'b1;
    step();
    vectors++;
    if (vga_plot !== 1'b0) begin
      miscompares++;
      $display("FAIL clip_x: got plot=%b want 0", vga_plot);
    end
    fig_x = 8'd5; fig_y = 7'd125; fig_colour = 3'd2;
    step();
    vectors++;
    if (vga_plot !== 1'b0) begin
      miscompares++;
      $display("FAIL clip_y: got plot=%b want 0", vga_plot);
    end
    fig_x = 8'd159; fig_y = 7'd119; fig_colour = 3'd5;
    step();
    vectors++;
    if (vga_plot !== 1'b1 || vga_x !== 8'd159 || vga_y !== 7'd119 || vga_colour !== 3'd5 || plot_count !== 16'd1) begin
      miscompares++;
      $display("FAIL corner_pixel: got plot=%b x=%0d y=%0d c=%0d cnt=%0d want 1 159 119 5 1",
               vga_plot, vga_x, vga_y, vga_colour, plot_count);
    end
    fig_plot = 1'b0; fig_done = 1'b1;
    step();
    vectors++;
    if (vga_plot !== 1'b0 || done !== 1'b1 || plot_count !== 16'd1) begin
      miscompares++;
      $display("FAIL bounds_done: got plot=%b done=%b cnt=%0d want 0 1 1", vga_plot, done, plot_count);
    end
    fig_done = 1'b0; start = 1'b0;
    step();
  endtask

  task automatic test_start_drop();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fill_x = 8'(10 + k); fill_y = 7'd20; fill_colour = 3'd4;
      fill_plot = 1'b1; fill_done = (k == 2);
      step();
    end
    fill_plot = 1'b0; fill_done = 1'b0;
    step();
    vectors++;
    if (fig_start !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_continues: got fig_start=%b want 1", fig_start);
    end
    for (int k = 0; k < 2; k++) begin
      fig_x = 8'(30 + k); fig_y = 7'd40; fig_colour = 3'd3;
      fig_plot = 1'b1; fig_done = (k == 1);
      step();
    end
    vectors++;
    if (done !== 1'b1 || plot_count !== 16'd5) begin
      miscompares++;
      $display("FAIL drop_done: got done=%b cnt=%0d want 1 5", done, plot_count);
    end
    fig_plot = 1'b0; fig_done = 1'b0;
    step();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_pulse: got done=%b want 0", done);
    end
    start = 1'b1;
    step();
    vectors++;
    if (plot_count !== 16'd0 || fill_start !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_restart: got cnt=%0d fill_start=%b want 0 1", plot_count, fill_start);
    end
  endtask

  task automatic test_reset_mid_fig();
    fill_done = 1'b1;
    step();
    fill_done = 1'b0;
    step();
    fig_x = 8'd7; fig_y = 7'd7; fig_colour = 3'd2; fig_plot = 1'b1;
    step();
    vectors++;
    if (vga_plot !== 1'b1 || fig_start !== 1'b1 || plot_count !== 16'd1) begin
      miscompares++;
      $display("FAIL prereset_fig: got plot=%b fig_start=%b cnt=%0d want 1 1 1", vga_plot, fig_start, plot_count);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({done, err, fill_start, fig_start, vga_plot} !== 5'b0 ||
        {vga_x, vga_y, vga_colour, plot_count} !== 34'b0) begin
      miscompares++;
      $display("FAIL async_reset: got ctrl=%b x=%0d y=%0d c=%0d cnt=%0d want all 0",
               {done, err, fill_start, fig_start, vga_plot}, vga_x, vga_y, vga_colour, plot_count);
    end
    fig_plot = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    vectors++;
    if (fill_start !== 1'b1 || fig_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_restart: got fill=%b fig=%b want 1 0", fill_start, fig_start);
    end
    start = 1'b0;
  endtask

  task automatic test_timeout();
    t_start = 1'b1;
    step();
    t_fill_done = 1'b1;
    step();
    t_fill_done = 1'b0;
    step();
    // first cycle in FIG; figure engine never answers
    for (int n = 0; n < 99; n++) step();
    vectors++;
    if (t_fig_start !== 1'b1 || t_done !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: got fig_start=%b done=%b want 1 0", t_fig_start, t_done);
    end
    step();
    vectors++;
    if (t_done !== 1'b1 || t_err !== 1'b1 || t_fig_start !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_abort: got done=%b err=%b fig_start=%b want 1 1 0", t_done, t_err, t_fig_start);
    end
    t_start = 1'b0;
    step();
    vectors++;
    if (t_done !== 1'b0 || t_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_idle: got done=%b err=%b want 0 1", t_done, t_err);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_bounds();
    test_start_drop();
    test_reset_mid_fig();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
